// File: rtl/mmult_pkg.sv
// Shared sizes, FSM state encoding and flattened-element offset helpers for the
// 4x4 matrix multiplier.
package mmult_pkg;

    localparam int MM_N  = 4;
    localparam int MM_DW = 8;
    localparam int MM_RW = 18;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Bit offset of operand element (i,j) inside a flattened 128-bit matrix.
    function automatic logic [6:0] op_off(input logic [1:0] i, input logic [1:0] j);
        return {i, j, 3'b000};
    endfunction

    // Bit offset of result element (i,j) inside the flattened 288-bit matrix.
    function automatic logic [8:0] res_off(input logic [1:0] i, input logic [1:0] j);
        logic [8:0] elem;
        elem = {5'b00000, i, j};
        return elem * 9'd18;
    endfunction

endpackage

// File: rtl/mmult_dot4.sv
// Combinational 4-term unsigned dot product of 8-bit operands into an
// 18-bit sum; the width holds 4*255*255 without wrapping.
module mmult_dot4
    import mmult_pkg::*;
(
    input  logic [MM_N-1:0][MM_DW-1:0] a,
    input  logic [MM_N-1:0][MM_DW-1:0] b,
    output logic [MM_RW-1:0]           dot
);

    logic [MM_N-1:0][MM_RW-1:0] prod;

    always_comb begin
        prod = '0;
        for (int k = 0; k < MM_N; k++) begin
            prod[k] = MM_RW'(a[k]) * MM_RW'(b[k]);
        end
    end

    assign dot = prod[0] + prod[1] + prod[2] + prod[3];

endmodule

// File: rtl/mmult.sv
// Sequential 4x4 unsigned matrix multiplier: latches both operands on start,
// writes one row of C per enabled cycle and holds a sticky valid when done.
module mmult
    import mmult_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [0:127] A_mat,
    input  logic [0:127] B_mat,
    output logic         valid,
    output logic [0:287] result
);

    state_t       state;
    state_t       state_next;
    logic [1:0]   row;
    logic [0:127] a_reg;
    logic [0:127] b_reg;

    logic [MM_N-1:0][MM_DW-1:0]            a_row;
    logic [MM_N-1:0][MM_N-1:0][MM_DW-1:0]  b_col;
    logic [MM_N-1:0][MM_RW-1:0]            dot;

    // The selected A row is shared by all four column units.
    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int k = 0; k < MM_N; k++) begin
            a_row[k] = a_reg[op_off(row, 2'(k)) +: MM_DW];
            for (int j = 0; j < MM_N; j++) begin
                b_col[j][k] = b_reg[op_off(2'(k), 2'(j)) +: MM_DW];
            end
        end
    end

    for (genvar j = 0; j < MM_N; j++) begin : g_col
        mmult_dot4 u_dot4 (
            .a   (a_row),
            .b   (b_col[j]),
            .dot (dot[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = CALC;
            CALC:    if (enable && row == 2'd3) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand and result registers are cleared on reset because unwritten
    // rows must read as zero; this is a register bank, not a RAM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row    <= 2'd0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else if (state == IDLE && enable) begin
            a_reg <= A_mat;
            b_reg <= B_mat;
            row   <= 2'd0;
        end else if (state == CALC && enable) begin
            for (int j = 0; j < MM_N; j++) begin
                result[res_off(row, 2'(j)) +: MM_RW] <= dot[j];
            end
            row <= row + 2'd1;
        end
    end

    assign valid = (state == DONE);

endmodule

// File: tb/tb_mmult.sv
// Directed self-checking bench for mmult: reference, identity, saturation,
// pause, mid-run reset and operand-stability scenarios.
module tb_mmult;

    typedef logic [0:127] mat_t;
    typedef logic [0:287] res_t;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    mat_t A_mat;
    mat_t B_mat;
    logic valid;
    res_t result;

    int tests = 0;
    int fails = 0;

    localparam mat_t REF_A = 128'hE1B61EA66B0CE834D75580DB1D2D27B7;
    localparam mat_t REF_B = 128'hB973386E0A9976BC8EB00B0298F8A0D3;
    localparam mat_t ID_A  = 128'h01000000000100000000010000000001;
    localparam mat_t ID_B  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam mat_t ALL_F = {128{1'b1}};

    mmult dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .A_mat   (A_mat),
        .B_mat   (B_mat),
        .valid   (valid),
        .result  (result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] op_el(input mat_t m, input int i, input int j);
        return m[(i*4+j)*8 +: 8];
    endfunction

    function automatic logic [17:0] res_el(input res_t r, input int i, input int j);
        return r[(i*4+j)*18 +: 18];
    endfunction

    function automatic res_t model(input mat_t a, input mat_t b);
        res_t r;
        int   s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(op_el(a, i, k)) * int'(op_el(b, k, j));
                r[(i*4+j)*18 +: 18] = 18'(s);
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Start edge, then count edges until valid; optional enable gap after pause_after rows.
    task automatic run(input mat_t a, input mat_t b, input int pause_after,
                       input int pause_len, output int lat);
        A_mat  = a;
        B_mat  = b;
        enable = 1'b1;
        step();
        lat = 0;
        while (!valid && lat < 50) begin
            if (lat == pause_after) begin
                enable = 1'b0;
                repeat (pause_len) begin
                    step();
                    lat++;
                end
                enable = 1'b1;
            end
            step();
            lat++;
        end
    endtask

    task automatic cmp_all(input string name, input res_t exp);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (res_el(result, i, j) !== res_el(exp, i, j)) begin
                    fails++;
                    $display("FAIL %s C(%0d,%0d): got %0d expected %0d", name, i, j,
                             res_el(result, i, j), res_el(exp, i, j));
                end
            end
        end
    endtask

    task automatic test_reset();
        A_mat = REF_A;
        B_mat = REF_B;
        do_reset();
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        tests++;
        if (result !== '0) begin
            fails++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
    endtask

    task automatic test_reference();
        int lat;
        do_reset();
        run(REF_A, REF_B, -1, 0, lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL ref_latency: got %0d expected 4", lat);
        end
        tests++;
        if (res_el(result, 0, 0) !== 18'd72937) begin
            fails++;
            $display("FAIL ref_c00: got %0d expected 72937", res_el(result, 0, 0));
        end
        tests++;
        if (res_el(result, 0, 1) !== 18'd100169) begin
            fails++;
            $display("FAIL ref_c01: got %0d expected 100169", res_el(result, 0, 1));
        end
        cmp_all("ref", model(REF_A, REF_B));
    endtask

    task automatic test_identity();
        int   lat;
        res_t exp;
        exp = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp[(i*4+j)*18 +: 18] = {10'd0, op_el(ID_B, i, j)};
        do_reset();
        run(ID_A, ID_B, -1, 0, lat);
        tests++;
        if (valid !== 1'b1) begin
            fails++;
            $display("FAIL id_valid: got %b expected 1", valid);
        end
        cmp_all("identity", exp);
    endtask

    task automatic test_saturation();
        int   lat;
        res_t exp;
        exp = '0;
        for (int e = 0; e < 16; e++) exp[e*18 +: 18] = 18'd260100;
        do_reset();
        run(ALL_F, ALL_F, -1, 0, lat);
        cmp_all("saturation", exp);
    endtask

    task automatic test_pause();
        int lat;
        do_reset();
        run(REF_A, REF_B, 2, 3, lat);
        tests++;
        if (lat !== 7) begin
            fails++;
            $display("FAIL pause_latency: got %0d expected 7", lat);
        end
        cmp_all("pause", model(REF_A, REF_B));
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        A_mat  = REF_A;
        B_mat  = REF_B;
        enable = 1'b1;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_valid: got %b expected 0", valid);
        end
        tests++;
        if (result !== '0) begin
            fails++;
            $display("FAIL midreset_result: got %h expected 0", result);
        end
        reset_n = 1'b1;
        enable  = 1'b0;
        step();
        run(ID_A, REF_B, -1, 0, lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL midreset_restart_latency: got %0d expected 4", lat);
        end
        cmp_all("restart", model(ID_A, REF_B));
    endtask

    task automatic test_stability();
        int lat;
        do_reset();
        A_mat  = REF_A;
        B_mat  = REF_B;
        enable = 1'b1;
        step();
        A_mat = ALL_F;
        B_mat = ID_B;
        lat   = 0;
        while (!valid && lat < 50) begin
            step();
            lat++;
        end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL stab_latency: got %0d expected 4", lat);
        end
        cmp_all("stab_run", model(REF_A, REF_B));
        A_mat = ID_A;
        B_mat = ALL_F;
        repeat (3) step();
        enable = 1'b0;
        repeat (2) step();
        tests++;
        if (valid !== 1'b1) begin
            fails++;
            $display("FAIL stab_valid_hold: got %b expected 1", valid);
        end
        cmp_all("stab_hold", model(REF_A, REF_B));
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        A_mat   = '0;
        B_mat   = '0;
        test_reset();
        test_reference();
        test_identity();
        test_saturation();
        test_pause();
        test_reset_mid();
        test_stability();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
